// File: rtl/spi_byte_sequencer_if.sv
// Command-side handshake between the command logic and the SPI byte sequencer.
interface spi_byte_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  abort;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  // Command logic side
  modport master (
    output start, tx_data, abort,
    input  ready, busy, rx_data, rx_valid
  );

  // Sequencer side
  modport slave (
    input  start, tx_data, abort,
    output ready, busy, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Mode-0 byte-wide SPI master that sequences an external clock divider: it arms and
// enables the divider, gates its output onto sclk, shifts MOSI MSB-first, captures
// MISO and frames each transfer with an active-low chip select.
module spi_byte_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SETUP_CYCLES = 125,
  parameter int unsigned HOLD_CYCLES  = 125
) (
  input  logic                     clock,
  input  logic                     reset,
  spi_byte_sequencer_if.slave      bus,
  output logic                     div_enable,
  output logic                     div_reset,
  input  logic                     div_clk,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     cs_n
);

  localparam int unsigned Msb        = DATA_WIDTH - 1;
  localparam int unsigned MaxCycles  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned TimerWidth = (MaxCycles > 1) ? $clog2(MaxCycles + 1) : 1;
  localparam int unsigned CntWidth   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StArm,
    StShift,
    StHold,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [CntWidth-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    div_clk_q;
  logic                    rise, fall;
  logic                    active_q, active_d;

  assign rise = div_clk & ~div_clk_q;
  assign fall = ~div_clk & div_clk_q;

  // States in which cs_n is asserted and abort is honoured.
  assign active_q = (state_q == StSetup) || (state_q == StArm) ||
                    (state_q == StShift) || (state_q == StHold);
  assign active_d = (state_d == StSetup) || (state_d == StArm) ||
                    (state_d == StShift) || (state_d == StHold);

  // Next-state, datapath updates and divider control.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    mosi_d     = mosi_q;
    div_enable = 1'b0;
    div_reset  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          timer_d   = '0;
          mosi_d    = bus.tx_data[Msb];
          state_d   = StSetup;
        end
      end
      StSetup: begin
        mosi_d = shift_q[Msb];
        if (timer_q == TimerWidth'(SETUP_CYCLES - 1)) begin
          state_d = StArm;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StArm: begin
        // Divider only updates while enabled, so clearing needs both.
        div_reset  = 1'b1;
        div_enable = 1'b1;
        state_d    = StShift;
      end
      StShift: begin
        div_enable = 1'b1;
        if (rise) begin
          shift_d   = {shift_q[DATA_WIDTH-2:0], miso};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (fall) begin
          if (bit_cnt_q == CntWidth'(DATA_WIDTH)) begin
            state_d = StHold;
            timer_d = '0;
          end else begin
            mosi_d = shift_q[Msb];
          end
        end
      end
      StHold: begin
        if (timer_q == TimerWidth'(HOLD_CYCLES - 1)) begin
          state_d   = StDone;
          rx_data_d = shift_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort drops the frame without delivering a word.
    if (bus.abort && active_q) begin
      state_d   = StIdle;
      rx_data_d = rx_data_q;
    end

    // Hold the divider cleared for as long as we are in reset.
    if (reset) begin
      div_reset  = 1'b1;
      div_enable = 1'b1;
    end

    cs_n_d = ~active_d;
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      div_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      div_clk_q <= div_clk;
    end
  end

  assign sclk         = div_clk & (state_q == StShift);
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;
  assign bus.ready    = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.rx_valid = (state_q == StDone);
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural 50 MHz -> 200 kHz divider.
module tb_spi_byte_sequencer;

  logic clock;
  logic reset;
  logic div_enable, div_reset, div_clk;
  logic sclk, mosi, miso, cs_n;
  logic loopback, miso_const;

  spi_byte_sequencer_if #(.DATA_WIDTH(8)) bus ();

  spi_byte_sequencer #(
    .DATA_WIDTH  (8),
    .SETUP_CYCLES(125),
    .HOLD_CYCLES (125)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .div_enable(div_enable),
    .div_reset (div_reset),
    .div_clk   (div_clk),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  assign miso = loopback ? mosi : miso_const;

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Divider model: cleared by reset&enable, goes OFF->HIGH, then 125 high / 125 low.
  logic div_clk_r = 1'b0;
  logic div_off   = 1'b1;
  int   div_cnt   = 0;
  always @(posedge clock) begin
    if (div_enable) begin
      if (div_reset) begin
        div_clk_r <= 1'b0;
        div_off   <= 1'b1;
        div_cnt   <= 0;
      end else if (div_off) begin
        div_off   <= 1'b0;
        div_clk_r <= 1'b1;
        div_cnt   <= 0;
      end else if (div_cnt == 124) begin
        div_cnt   <= 0;
        div_clk_r <= ~div_clk_r;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end
  assign div_clk = div_clk_r;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int rise_cnt, rxv_cnt;
  int first_rise_cyc, last_rise_cyc, last_fall_cyc, cs_fall_cyc, cs_rise_cyc;
  int hi_min, hi_max, lo_min, lo_max, min_gap;
  bit cs_rise_seen;
  logic sclk_p = 1'b0;
  logic cs_p   = 1'b1;
  logic [15:0] mosi_bits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clear_stats();
    rise_cnt     = 0;
    rxv_cnt      = 0;
    mosi_bits    = '0;
    hi_min       = 1 << 30;
    hi_max       = 0;
    lo_min       = 1 << 30;
    lo_max       = 0;
    min_gap      = 1 << 30;
    cs_rise_seen = 1'b0;
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic tick();
    int d;
    @(negedge clock);
    cyc++;
    if (sclk && !sclk_p) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[14:0], mosi};
      if (rise_cnt == 1) begin
        first_rise_cyc = cyc;
      end else begin
        d = cyc - last_fall_cyc;
        if (d < lo_min) lo_min = d;
        if (d > lo_max) lo_max = d;
      end
      last_rise_cyc = cyc;
    end
    if (!sclk && sclk_p) begin
      d = cyc - last_rise_cyc;
      if (d < hi_min) hi_min = d;
      if (d > hi_max) hi_max = d;
      last_fall_cyc = cyc;
    end
    if (cs_n && !cs_p) begin
      cs_rise_cyc  = cyc;
      cs_rise_seen = 1'b1;
    end
    if (!cs_n && cs_p) begin
      cs_fall_cyc = cyc;
      if (cs_rise_seen && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
    end
    if (bus.rx_valid) rxv_cnt++;
    sclk_p = sclk;
    cs_p   = cs_n;
  endtask

  task automatic wait_rx(input int limit);
    int n = 0;
    while (!bus.rx_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rises(input int k, input int limit);
    int n = 0;
    while (rise_cnt < k && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_start(input logic [7:0] data);
    bus.tx_data = data;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  logic [7:0] rx_first, rx_second, exp_second;

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.tx_data = '0;
    loopback    = 1'b0;
    miso_const  = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) tick();
    chk("rst_div_reset", div_reset, 1);
    chk("rst_div_enable", div_enable, 1);
    reset = 1'b0;
    tick();
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_div_enable_lo", div_enable, 0);
    chk("rst_div_reset_lo", div_reset, 0);

    // Loopback 0xA5 with timing checks
    clear_stats();
    loopback = 1'b1;
    do_start(8'hA5);
    chk("a5_cs_low_next", cs_n, 0);
    chk("a5_busy", bus.busy, 1);
    wait_rx(3000);
    chk("a5_rx_valid", bus.rx_valid, 1);
    chk("a5_rx_data", bus.rx_data, 8'hA5);
    chk("a5_cs_high_with_valid", cs_n, 1);
    chk("a5_not_ready_in_done", bus.ready, 0);
    tick();
    chk("a5_ready_after", bus.ready, 1);
    chk("a5_valid_pulse", bus.rx_valid, 0);
    repeat (5) tick();
    chk("a5_rises", rise_cnt, 8);
    chk("a5_mosi_bits", mosi_bits[7:0], 8'hA5);
    chk("a5_valid_count", rxv_cnt, 1);
    chk_rng("a5_cs_to_first_rise", first_rise_cyc - cs_fall_cyc, 126, 128);
    chk("a5_hi_min", hi_min, 125);
    chk("a5_hi_max", hi_max, 125);
    chk("a5_lo_min", lo_min, 125);
    chk("a5_lo_max", lo_max, 125);
    chk_rng("a5_last_fall_to_cs", cs_rise_cyc - last_fall_cyc, 126, 128);

    // Abort at the 5th sclk rise
    clear_stats();
    loopback = 1'b0;
    miso_const = 1'b1;
    do_start(8'h3C);
    wait_rises(5, 2000);
    chk("ab_fifth_rise", rise_cnt, 5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_cs_n", cs_n, 1);
    chk("ab_div_enable", div_enable, 0);
    chk("ab_ready", bus.ready, 1);
    chk("ab_sclk", sclk, 0);
    repeat (400) tick();
    chk("ab_no_valid", rxv_cnt, 0);
    chk("ab_rx_kept", bus.rx_data, 8'hA5);

    // Reset mid-shift after 3 bits, then a normal 0x5A transfer
    clear_stats();
    loopback = 1'b1;
    do_start(8'h11);
    wait_rises(3, 1000);
    chk("rs_third_rise", rise_cnt, 3);
    reset = 1'b1;
    tick();
    chk("rs_cs_n", cs_n, 1);
    chk("rs_sclk", sclk, 0);
    chk("rs_ready", bus.ready, 1);
    chk("rs_mosi", mosi, 0);
    chk("rs_rx_data", bus.rx_data, 8'h00);
    chk("rs_div_reset", div_reset, 1);
    reset = 1'b0;
    repeat (300) tick();
    chk("rs_no_valid", rxv_cnt, 0);
    clear_stats();
    do_start(8'h5A);
    wait_rx(3000);
    chk("5a_rx_valid", bus.rx_valid, 1);
    chk("5a_rx_data", bus.rx_data, 8'h5A);
    tick();
    chk("5a_mosi_bits", mosi_bits[7:0], 8'h5A);
    chk("5a_rises", rise_cnt, 8);

    // MISO tied high, send 0x00
    clear_stats();
    loopback = 1'b0;
    miso_const = 1'b1;
    do_start(8'h00);
    wait_rx(3000);
    chk("m1_rx_data", bus.rx_data, 8'hFF);
    chk("m1_mosi_bits", mosi_bits[7:0], 8'h00);
    chk("m1_rises", rise_cnt, 8);
    tick();

    // MISO tied low, send 0xC3
    clear_stats();
    miso_const = 1'b0;
    do_start(8'hC3);
    wait_rx(3000);
    chk("m0_rx_data", bus.rx_data, 8'h00);
    chk("m0_mosi_bits", mosi_bits[7:0], 8'hC3);
    tick();

    // start held high with tx_data changing every cycle
    clear_stats();
    loopback    = 1'b1;
    rx_first    = '0;
    rx_second   = '0;
    exp_second  = '0;
    bus.tx_data = 8'h96;
    bus.start   = 1'b1;
    for (int n = 0; n < 6000 && rxv_cnt < 2; n++) begin
      tick();
      if (bus.rx_valid && rxv_cnt == 1) rx_first = bus.rx_data;
      if (bus.rx_valid && rxv_cnt == 2) rx_second = bus.rx_data;
      bus.tx_data = bus.tx_data + 8'h3B;
      if (bus.ready && rxv_cnt == 1) exp_second = bus.tx_data;
    end
    bus.start = 1'b0;
    chk("hs_two_transfers", rxv_cnt, 2);
    chk("hs_first_latched", rx_first, 8'h96);
    chk("hs_second_latched", rx_second, exp_second);
    chk_rng("hs_cs_high_gap", min_gap, 2, 1 << 30);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("hs_abort_ready", bus.ready, 1);

    // Abort in idle has no effect; start beats abort
    bus.abort = 1'b1;
    tick();
    chk("idle_abort_ready", bus.ready, 1);
    chk("idle_abort_cs_n", cs_n, 1);
    clear_stats();
    bus.tx_data = 8'h42;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    chk("sa_cs_low", cs_n, 0);
    chk("sa_busy", bus.busy, 1);
    wait_rx(3000);
    chk("sa_rx_data", bus.rx_data, 8'h42);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
